// File: rtl/conv_pkg.sv
// Shared definitions for the sliding-window convolution path: move directions
// used by the scan controller, window memory and pixel_pos, plus scan states.
package conv_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t RIGHT = 2'b00;
    localparam dir_t LEFT  = 2'b01;
    localparam dir_t DOWN  = 2'b10;  // down after finishing a right-moving row
    localparam dir_t DOWN2 = 2'b11;  // down after finishing a left-moving row

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FILL,
        ST_CAPTURE,
        ST_CONV,
        ST_FINISH
    } scan_state_e;

endpackage

// File: rtl/serp_step.sv
// Combinational serpentine stepper: from the current window position, yields
// the next position, the direction that applies there, and a final-window flag.
module serp_step
    import conv_pkg::*;
#(
    parameter int unsigned XW = 6,
    parameter int unsigned YW = 6
) (
    input  logic [XW-1:0] curr_x,
    input  logic [YW-1:0] curr_y,
    input  logic [XW-1:0] xl,
    input  logic [YW-1:0] yl,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y,
    output logic [1:0]    next_dir,
    output logic          is_final
);

    // Even rows sweep right up to xl, odd rows sweep left down to 0, then step down.
    function automatic dir_t dir_at(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                    input logic [XW-1:0] lim);
        dir_t d;
        if (!y[0]) begin
            d = (x < lim) ? RIGHT : DOWN;
        end else begin
            d = (x != '0) ? LEFT : DOWN2;
        end
        return d;
    endfunction

    dir_t cur_dir;

    always_comb begin
        cur_dir = dir_at(curr_x, curr_y, xl);
        next_x  = curr_x;
        next_y  = curr_y;
        case (cur_dir)
            RIGHT:   next_x = curr_x + XW'(1);
            LEFT:    next_x = curr_x - XW'(1);
            default: next_y = curr_y + YW'(1);
        endcase
    end

    assign next_dir = dir_at(next_x, next_y, xl);
    assign is_final = (curr_y == yl) && (curr_x == (yl[0] ? '0 : xl));

endmodule

// File: rtl/conv_scan_ctrl.sv
// Scan controller for the convolution datapath: walks the kernel window over the
// image in serpentine order and handshakes with the window memory and conv engine.
module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned X_MAX      = 60,
    parameter int unsigned Y_MAX      = 60,
    parameter int unsigned MAX_KERNAL = 31
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(X_MAX):0]     img_width,
    input  logic [$clog2(Y_MAX):0]     img_height,
    input  logic [7:0]                 kernel_size,
    input  logic                       new_sample_ready,
    input  logic                       conv_done,
    output logic                       new_trans,
    output logic                       new_sample_req,
    output logic [$clog2(X_MAX)-1:0]   curr_x,
    output logic [$clog2(Y_MAX)-1:0]   curr_y,
    output logic [1:0]                 next_dir,
    output logic                       conv_start,
    output logic [$clog2(X_MAX)-1:0]   out_x,
    output logic [$clog2(Y_MAX)-1:0]   out_y,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int unsigned XW = $clog2(X_MAX);
    localparam int unsigned YW = $clog2(Y_MAX);

    scan_state_e   state_q, state_d;
    logic [XW-1:0] xl_q, xl_d;
    logic [YW-1:0] yl_q, yl_d;
    logic [XW-1:0] curr_x_q, curr_x_d;
    logic [YW-1:0] curr_y_q, curr_y_d;
    dir_t          next_dir_q, next_dir_d;
    logic [XW-1:0] out_x_q, out_x_d;
    logic [YW-1:0] out_y_q, out_y_d;
    logic          final_q, final_d;
    logic          fill_first_q, fill_first_d;
    logic          new_trans_q, new_trans_d;
    logic          new_sample_req_q, new_sample_req_d;
    logic          conv_start_q, conv_start_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;
    logic          busy_q, busy_d;

    logic [31:0]   k_ext, w_ext, h_ext;
    logic          cfg_bad;
    logic [XW-1:0] xl_new;
    logic [YW-1:0] yl_new;
    dir_t          init_dir;

    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;
    logic [1:0]    step_dir;
    logic          step_final;

    serp_step #(
        .XW (XW),
        .YW (YW)
    ) u_serp_step (
        .curr_x   (curr_x_q),
        .curr_y   (curr_y_q),
        .xl       (xl_q),
        .yl       (yl_q),
        .next_x   (step_x),
        .next_y   (step_y),
        .next_dir (step_dir),
        .is_final (step_final)
    );

    // Start-time configuration check and limit computation.
    always_comb begin
        k_ext   = 32'(kernel_size);
        w_ext   = 32'(img_width);
        h_ext   = 32'(img_height);
        cfg_bad = (k_ext == 32'd0) || !kernel_size[0] || (k_ext > MAX_KERNAL) ||
                  (k_ext > w_ext) || (k_ext > h_ext) ||
                  (w_ext > X_MAX) || (h_ext > Y_MAX);
        xl_new  = XW'(w_ext - k_ext);
        yl_new  = YW'(h_ext - k_ext);
        if (xl_new != '0) begin
            init_dir = RIGHT;
        end else if (yl_new != '0) begin
            init_dir = DOWN;
        end else begin
            init_dir = RIGHT;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d          = state_q;
        xl_d             = xl_q;
        yl_d             = yl_q;
        curr_x_d         = curr_x_q;
        curr_y_d         = curr_y_q;
        next_dir_d       = next_dir_q;
        out_x_d          = out_x_q;
        out_y_d          = out_y_q;
        final_d          = final_q;
        fill_first_d     = 1'b0;
        new_trans_d      = 1'b0;
        new_sample_req_d = 1'b0;
        conv_start_d     = 1'b0;
        done_d           = 1'b0;
        cfg_err_d        = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            xl_d        = xl_new;
                            yl_d        = yl_new;
                            curr_x_d    = '0;
                            curr_y_d    = '0;
                            next_dir_d  = init_dir;
                            final_d     = 1'b0;
                            new_trans_d = 1'b1;
                            state_d     = ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    fill_first_d = 1'b1;
                    state_d      = ST_FILL;
                end
                ST_FILL: begin
                    // A ready already high on the entry cycle belongs to the previous window.
                    if (!fill_first_q && new_sample_ready) begin
                        new_sample_req_d = 1'b1;
                        state_d          = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    out_x_d      = curr_x_q;
                    out_y_d      = curr_y_q;
                    final_d      = step_final;
                    if (!step_final) begin
                        curr_x_d   = step_x;
                        curr_y_d   = step_y;
                        next_dir_d = step_dir;
                    end
                    conv_start_d = 1'b1;
                    state_d      = ST_CONV;
                end
                ST_CONV: begin
                    if (conv_done) begin
                        if (final_q) begin
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            fill_first_d = 1'b1;
                            state_d      = ST_FILL;
                        end
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q          <= ST_IDLE;
            xl_q             <= '0;
            yl_q             <= '0;
            curr_x_q         <= '0;
            curr_y_q         <= '0;
            next_dir_q       <= RIGHT;
            out_x_q          <= '0;
            out_y_q          <= '0;
            final_q          <= 1'b0;
            fill_first_q     <= 1'b0;
            new_trans_q      <= 1'b0;
            new_sample_req_q <= 1'b0;
            conv_start_q     <= 1'b0;
            done_q           <= 1'b0;
            cfg_err_q        <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            xl_q             <= xl_d;
            yl_q             <= yl_d;
            curr_x_q         <= curr_x_d;
            curr_y_q         <= curr_y_d;
            next_dir_q       <= next_dir_d;
            out_x_q          <= out_x_d;
            out_y_q          <= out_y_d;
            final_q          <= final_d;
            fill_first_q     <= fill_first_d;
            new_trans_q      <= new_trans_d;
            new_sample_req_q <= new_sample_req_d;
            conv_start_q     <= conv_start_d;
            done_q           <= done_d;
            cfg_err_q        <= cfg_err_d;
            busy_q           <= busy_d;
        end
    end

    assign new_trans      = new_trans_q;
    assign new_sample_req = new_sample_req_q;
    assign curr_x         = curr_x_q;
    assign curr_y         = curr_y_q;
    assign next_dir       = next_dir_q;
    assign conv_start     = conv_start_q;
    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl: memory/engine responders, a window
// logger, a serpentine reference model, vector table, corner sequences, random frames.
module tb_conv_scan_ctrl;
    import conv_pkg::*;

    localparam int XMAX   = 60;
    localparam int YMAX   = 60;
    localparam int MAXK   = 31;
    localparam int LOG    = 2048;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       n_rst, start, abort;
    logic [6:0] img_width, img_height;
    logic [7:0] kernel_size;
    logic       new_sample_ready, conv_done;
    logic       new_trans, new_sample_req, conv_start, busy, done, cfg_err;
    logic [5:0] curr_x, curr_y, out_x, out_y;
    logic [1:0] next_dir;

    conv_scan_ctrl dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .start            (start),
        .abort            (abort),
        .img_width        (img_width),
        .img_height       (img_height),
        .kernel_size      (kernel_size),
        .new_sample_ready (new_sample_ready),
        .conv_done        (conv_done),
        .new_trans        (new_trans),
        .new_sample_req   (new_sample_req),
        .curr_x           (curr_x),
        .curr_y           (curr_y),
        .next_dir         (next_dir),
        .conv_start       (conv_start),
        .out_x            (out_x),
        .out_y            (out_y),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int d;
        int c;
    } rec_t;

    typedef struct {
        int w;
        int h;
        int k;
        int rl;
        int cl;
        bit hold;
        int exp_err;
        int exp_win;
    } vec_t;

    rec_t req_log [LOG];
    rec_t cs_log  [LOG];
    int   n_req = 0, n_cs = 0, n_trans = 0, n_done = 0, n_err = 0, n_busy = 0;
    int   trans_cyc = 0, done_cyc = 0, cdone_cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   rdy_lat = 4, cdone_lat = 2;
    bit   hold_ready = 1'b0;
    int   last_b_req = 0, last_b_cs = 0;

    // Window memory and convolution engine behaviour.
    initial begin
        int rcnt, ccnt;
        rcnt = 0;
        ccnt = 0;
        new_sample_ready = 1'b0;
        conv_done = 1'b0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            if (hold_ready) begin
                new_sample_ready = 1'b1;
            end else if (new_trans || new_sample_req) begin
                new_sample_ready = 1'b0;
                rcnt = rdy_lat;
            end else if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) new_sample_ready = 1'b1;
            end
            if (conv_start) begin
                ccnt = cdone_lat;
                if (cdone_lat == 0) begin
                    conv_done = 1'b1;
                    cdone_cyc = cyc;
                end
            end else if (ccnt > 0) begin
                ccnt--;
                if (ccnt == 0) begin
                    conv_done = 1'b1;
                    cdone_cyc = cyc;
                end
            end
        end
    end

    // Event logger.
    initial begin
        forever begin
            @(negedge clk);
            if (new_sample_req) begin
                req_log[n_req % LOG] = '{int'(curr_x), int'(curr_y), int'(next_dir), cyc};
                n_req++;
            end
            if (conv_start) begin
                cs_log[n_cs % LOG] = '{int'(out_x), int'(out_y), 0, cyc};
                n_cs++;
            end
            if (new_trans) begin
                n_trans++;
                trans_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cfg_err) n_err++;
            if (busy) n_busy++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one start request; for accepted frames compares every window against the model.
    task automatic run_frame(input int w, input int h, input int k, input int rl, input int cl,
                             input bit hold, output int got_err, output int got_win);
        int b_req, b_cs, b_tr, b_done, b_err, b_busy, t, xl, yl, nwin, ed;
        int qx[$];
        int qy[$];
        rec_t r, c;
        rdy_lat = rl;
        cdone_lat = cl;
        hold_ready = hold;
        b_req = n_req; b_cs = n_cs; b_tr = n_trans; b_done = n_done; b_err = n_err; b_busy = n_busy;
        last_b_req = b_req;
        last_b_cs = b_cs;
        img_width = 7'(w);
        img_height = 7'(h);
        kernel_size = 8'(k);
        start = 1'b1;
        step();
        start = 1'b0;
        img_width = 7'($urandom);
        img_height = 7'($urandom);
        kernel_size = 8'($urandom);
        step();
        got_err = n_err - b_err;
        got_win = 0;
        if (got_err != 0 || n_trans == b_tr) begin
            step();
            chk_eq("reject_no_trans", n_trans - b_tr, 0);
            chk_eq("reject_no_busy", n_busy - b_busy, 0);
            return;
        end
        t = 0;
        while (n_done == b_done && t < BUDGET) begin
            step();
            t++;
        end
        chk_eq("frame_completes", n_done - b_done, 1);
        if (n_done == b_done) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        step();
        chk_eq("idle_after_done", int'(busy), 0);
        chk_eq("one_new_trans", n_trans - b_tr, 1);
        got_win = n_req - b_req;
        xl = w - k;
        yl = h - k;
        for (int y = 0; y <= yl; y++) begin
            for (int i = 0; i <= xl; i++) begin
                qx.push_back((y % 2 == 0) ? i : xl - i);
                qy.push_back(y);
            end
        end
        nwin = qx.size();
        chk_eq("conv_start_count", n_cs - b_cs, nwin);
        if (got_win != nwin || n_cs - b_cs != nwin) return;
        for (int i = 0; i < nwin; i++) begin
            if (i == nwin - 1) begin
                ed = (nwin == 1) ? int'(RIGHT) : ((yl % 2 == 0) ? int'(DOWN) : int'(DOWN2));
            end else if (qy[i+1] > qy[i]) begin
                ed = (qy[i] % 2 == 0) ? int'(DOWN) : int'(DOWN2);
            end else if (qx[i+1] > qx[i]) begin
                ed = int'(RIGHT);
            end else begin
                ed = int'(LEFT);
            end
            r = req_log[(b_req + i) % LOG];
            c = cs_log[(b_cs + i) % LOG];
            n_chk++;
            if (r.x != qx[i] || r.y != qy[i] || r.d != ed || c.x != qx[i] || c.y != qy[i]) begin
                n_fail++;
                $display("FAIL window %0d (W=%0d H=%0d K=%0d): req (%0d,%0d) dir %0d conv (%0d,%0d), expected (%0d,%0d) dir %0d",
                         i, w, h, k, r.x, r.y, r.d, c.x, c.y, qx[i], qy[i], ed);
            end
        end
    endtask

    initial begin
        vec_t vecs[12];
        int   ge, gw, t, bd, br, ee, ew, w, h, k;
        int   cx[6];
        int   cy[6];
        int   cd[5];
        rec_t r;

        vecs[0]  = '{5, 4, 3, 4, 2, 1'b0, 0, 6};
        vecs[1]  = '{3, 3, 3, 2, 1, 1'b0, 0, 1};
        vecs[2]  = '{3, 6, 3, 3, 2, 1'b0, 0, 4};
        vecs[3]  = '{5, 5, 4, 2, 2, 1'b0, 1, 0};
        vecs[4]  = '{5, 5, 7, 2, 2, 1'b0, 1, 0};
        vecs[5]  = '{5, 5, 0, 2, 2, 1'b0, 1, 0};
        vecs[6]  = '{61, 40, 3, 2, 2, 1'b0, 1, 0};
        vecs[7]  = '{8, 4, 5, 2, 2, 1'b0, 1, 0};
        vecs[8]  = '{7, 3, 3, 1, 0, 1'b0, 0, 5};
        vecs[9]  = '{60, 60, 31, 1, 1, 1'b0, 0, 900};
        vecs[10] = '{4, 5, 1, 1, 0, 1'b1, 0, 20};
        vecs[11] = '{33, 40, 33, 2, 2, 1'b0, 1, 0};
        cx = '{0, 1, 2, 2, 1, 0};
        cy = '{0, 0, 0, 1, 1, 1};
        cd = '{0, 0, 2, 1, 1};

        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        img_width = '0;
        img_height = '0;
        kernel_size = '0;
        repeat (3) step();
        chk_eq("reset_busy", int'(busy), 0);
        chk_eq("reset_pulses", int'({new_trans, new_sample_req, conv_start, done, cfg_err}), 0);
        chk_eq("reset_curr", int'({curr_x, curr_y}), 0);
        chk_eq("reset_out", int'({out_x, out_y}), 0);
        chk_eq("reset_next_dir", int'(next_dir), int'(RIGHT));
        n_rst = 1'b1;
        step();

        foreach (vecs[i]) begin
            run_frame(vecs[i].w, vecs[i].h, vecs[i].k, vecs[i].rl, vecs[i].cl, vecs[i].hold, ge, gw);
            chk_eq($sformatf("vec%0d_cfg_err", i), ge, vecs[i].exp_err);
            chk_eq($sformatf("vec%0d_windows", i), gw, vecs[i].exp_win);
        end

        // Explicit serpentine order for the 5x4 image, 3x3 kernel.
        run_frame(5, 4, 3, 4, 2, 1'b0, ge, gw);
        chk_eq("case1_windows", gw, 6);
        if (gw == 6) begin
            for (int i = 0; i < 6; i++) begin
                r = req_log[(last_b_req + i) % LOG];
                chk_eq($sformatf("case1_x%0d", i), r.x, cx[i]);
                chk_eq($sformatf("case1_y%0d", i), r.y, cy[i]);
                if (i < 5) chk_eq($sformatf("case1_dir%0d", i), r.d, cd[i]);
            end
        end
        chk_eq("case1_final_pos_held", int'(curr_x) * 100 + int'(curr_y), 1);

        // Single window: done follows conv_done by one cycle.
        run_frame(3, 3, 3, 2, 1, 1'b0, ge, gw);
        chk_eq("single_done_latency", done_cyc - cdone_cyc, 1);
        chk_eq("single_pos_unchanged", int'({curr_x, curr_y}), 0);
        chk_eq("single_next_dir", int'(next_dir), int'(RIGHT));

        // Ready held high across FILL entry; conv_done coincident with conv_start.
        run_frame(5, 4, 3, 1, 0, 1'b1, ge, gw);
        chk_eq("stale_windows", gw, 6);
        if (gw == 6) begin
            chk_eq("stale_first_req", req_log[last_b_req % LOG].c - trans_cyc, 3);
            chk_eq("stale_req_spacing", req_log[(last_b_req + 1) % LOG].c - req_log[last_b_req % LOG].c, 4);
            chk_eq("stale_conv_start", cs_log[last_b_cs % LOG].c - req_log[last_b_req % LOG].c, 1);
            chk_eq("same_cycle_done", done_cyc - req_log[(last_b_req + 5) % LOG].c, 2);
        end
        hold_ready = 1'b0;

        // Abort during CONV of the third window, then restart.
        rdy_lat = 2;
        cdone_lat = 5;
        step();
        bd = n_cs;
        img_width = 7'd5;
        img_height = 7'd4;
        kernel_size = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        t = 0;
        while (n_cs < bd + 3 && t < 500) begin
            step();
            t++;
        end
        chk_eq("abort_reached_window3", n_cs - bd, 3);
        abort = 1'b1;
        bd = n_done;
        br = n_req;
        step();
        abort = 1'b0;
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_pulses", int'({new_trans, new_sample_req, conv_start, done}), 0);
        chk_eq("abort_hold_pos", int'(curr_x) * 100 + int'(curr_y), 201);
        chk_eq("abort_hold_dir", int'(next_dir), int'(LEFT));
        repeat (10) step();
        chk_eq("abort_no_done", n_done - bd, 0);
        chk_eq("abort_no_req", n_req - br, 0);
        run_frame(5, 4, 3, 3, 1, 1'b0, ge, gw);
        chk_eq("restart_windows", gw, 6);

        // Reset mid-frame.
        rdy_lat = 3;
        cdone_lat = 3;
        img_width = 7'd5;
        img_height = 7'd4;
        kernel_size = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        bd = n_done;
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk_eq("midreset_busy", int'(busy), 0);
        chk_eq("midreset_curr", int'({curr_x, curr_y, next_dir}), 0);
        repeat (6) step();
        chk_eq("midreset_no_done", n_done - bd, 0);

        // Random configurations against the rule-based model.
        for (int n = 0; n < 25; n++) begin
            w = $urandom_range(1, 10);
            h = $urandom_range(1, 10);
            k = $urandom_range(0, 9);
            ee = (k == 0 || k % 2 == 0 || k > MAXK || k > w || k > h || w > XMAX || h > YMAX) ? 1 : 0;
            ew = ee ? 0 : (w - k + 1) * (h - k + 1);
            run_frame(w, h, k, $urandom_range(1, 5), $urandom_range(0, 4), ($urandom_range(0, 3) == 0), ge, gw);
            chk_eq($sformatf("rand%0d_cfg_err", n), ge, ee);
            chk_eq($sformatf("rand%0d_windows", n), gw, ew);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
